// File: rtl/twiddle_pkg.sv
// Shared encodings and derived widths for the twiddle frame sequencer and its
// return monitor.
package twiddle_pkg;

  localparam int N_SAMPLES_DEF = 8;
  localparam int TIMEOUT_DEF   = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FEED  = ST_FEED,
    S_DRAIN = ST_DRAIN
  } state_e;

  // Counters need one extra bit so that the value N_SAMPLES itself is representable.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int tmo_width(input int t);
    return $clog2(t + 1);
  endfunction

  localparam int NB_CNT = $clog2(N_SAMPLES_DEF) + 1;
  localparam int NB_TMO = $clog2(TIMEOUT_DEF + 1);

endpackage

// File: rtl/twiddle_return_monitor.sv
// Counts beats coming back from the twiddle stage, judges o_last legality and
// times the DRAIN phase.
module twiddle_return_monitor
  import twiddle_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int CNT_W     = NB_CNT,
  parameter int TMO_W     = NB_TMO
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_state,
  input  logic       i_abort,
  input  logic       i_tw_valid,
  input  logic       i_tw_last,
  output logic       ret_done,
  output logic       proto_err_evt,
  output logic       timeout_evt
);

  localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] RET_FULL = CNT_W'(N_SAMPLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic             active, in_drain, last_beat, beyond, last_ok;

  always_comb begin
    active        = (i_state != ST_IDLE);
    in_drain      = (i_state == ST_DRAIN);
    last_beat     = i_tw_valid && (ret_cnt_q == RET_LAST);
    beyond        = i_tw_valid && (ret_cnt_q == RET_FULL);
    last_ok       = i_tw_last && last_beat && in_drain;
    ret_done      = active && last_ok;
    proto_err_evt = active && ((i_tw_last && !last_ok) || beyond);
    // A last on the final allowed DRAIN cycle still counts as a clean finish.
    timeout_evt   = in_drain && (timer_q == TMO_LAST) && !last_ok && !proto_err_evt;

    ret_cnt_d = ret_cnt_q;
    if (!active || i_abort) begin
      ret_cnt_d = '0;
    end else if (i_tw_valid) begin
      ret_cnt_d = ret_cnt_q + CNT_W'(1);
    end

    timer_d = '0;
    if (in_drain && !i_abort) begin
      timer_d = timer_q + TMO_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ret_cnt_q <= '0;
      timer_q   <= '0;
    end else begin
      ret_cnt_q <= ret_cnt_d;
      timer_q   <= timer_d;
    end
  end

endmodule

// File: rtl/twiddle_frame_sequencer.sv
// Admits one frame of N_SAMPLES four-lane beats, forwards it to the twiddle
// stage with one cycle of latency and tracks completion, errors and frame count.
module twiddle_frame_sequencer
  import twiddle_pkg::*;
#(
  parameter int NB_DATA   = 10,
  parameter int N_SAMPLES = 8,
  parameter int TIMEOUT   = 64,
  parameter int NB_FRAME  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_clr_err,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [2*NB_DATA-1:0]   i_in_signal_0,
  input  logic [2*NB_DATA-1:0]   i_in_signal_1,
  input  logic [2*NB_DATA-1:0]   i_in_signal_2,
  input  logic [2*NB_DATA-1:0]   i_in_signal_3,
  output logic                   o_tw_valid,
  output logic [2*NB_DATA-1:0]   o_tw_signal_0,
  output logic [2*NB_DATA-1:0]   o_tw_signal_1,
  output logic [2*NB_DATA-1:0]   o_tw_signal_2,
  output logic [2*NB_DATA-1:0]   o_tw_signal_3,
  input  logic                   i_tw_valid,
  input  logic                   i_tw_last,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [NB_FRAME-1:0]    o_frame_cnt,
  output logic                   o_proto_err,
  output logic                   o_timeout_err
);

  localparam int LANE_W = 2 * NB_DATA;
  localparam int CNT_W  = cnt_width(N_SAMPLES);
  localparam int TMO_W  = tmo_width(TIMEOUT);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           in_cnt_q, in_cnt_d;
  logic                       vld_p1_q, vld_p1_d;
  logic [3:0][LANE_W-1:0]     lane_p1_q, lane_p1_d;
  logic                       done_q, done_d;
  logic [NB_FRAME-1:0]        frame_cnt_q, frame_cnt_d;
  logic                       proto_err_q, proto_err_d;
  logic                       timeout_err_q, timeout_err_d;

  logic hs, ret_done, proto_err_evt, timeout_evt;
  logic done_set, proto_set, tmo_set;

  twiddle_return_monitor #(
    .N_SAMPLES (N_SAMPLES),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W),
    .TMO_W     (TMO_W)
  ) u_ret_mon (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_state       (state_q),
    .i_abort       (i_abort),
    .i_tw_valid    (i_tw_valid),
    .i_tw_last     (i_tw_last),
    .ret_done      (ret_done),
    .proto_err_evt (proto_err_evt),
    .timeout_evt   (timeout_evt)
  );

  assign o_in_ready = (state_q == S_FEED) && (in_cnt_q < CNT_W'(N_SAMPLES));
  assign hs         = i_in_valid && o_in_ready;

  // Abort outranks every completion or error event in the same cycle.
  assign done_set  = ret_done && !i_abort;
  assign proto_set = proto_err_evt && !i_abort;
  assign tmo_set   = timeout_evt && !i_abort;

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    if (i_abort) begin
      state_d  = S_IDLE;
      in_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_cnt_d = '0;
          if (i_start) state_d = S_FEED;
        end
        S_FEED: begin
          if (proto_err_evt) begin
            state_d = S_IDLE;
          end else if (hs) begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
            if (in_cnt_q == CNT_W'(N_SAMPLES - 1)) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (proto_err_evt || ret_done || timeout_evt) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    vld_p1_d  = hs && !i_abort;
    lane_p1_d = lane_p1_q;
    if (hs && !i_abort) begin
      lane_p1_d = {i_in_signal_3, i_in_signal_2, i_in_signal_1, i_in_signal_0};
    end

    done_d        = done_set;
    frame_cnt_d   = frame_cnt_q + NB_FRAME'(done_set);
    // A set event in the same cycle as a clear leaves the flag set.
    proto_err_d   = proto_set | (proto_err_q & ~i_clr_err);
    timeout_err_d = tmo_set | (timeout_err_q & ~i_clr_err);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      in_cnt_q      <= '0;
      vld_p1_q      <= 1'b0;
      lane_p1_q     <= '0;
      done_q        <= 1'b0;
      frame_cnt_q   <= '0;
      proto_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_cnt_q      <= in_cnt_d;
      vld_p1_q      <= vld_p1_d;
      lane_p1_q     <= lane_p1_d;
      done_q        <= done_d;
      frame_cnt_q   <= frame_cnt_d;
      proto_err_q   <= proto_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign o_tw_valid    = vld_p1_q;
  assign o_tw_signal_0 = lane_p1_q[0];
  assign o_tw_signal_1 = lane_p1_q[1];
  assign o_tw_signal_2 = lane_p1_q[2];
  assign o_tw_signal_3 = lane_p1_q[3];
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = done_q;
  assign o_frame_cnt   = frame_cnt_q;
  assign o_proto_err   = proto_err_q;
  assign o_timeout_err = timeout_err_q;

endmodule

// File: tb/tb_twiddle_frame_sequencer.sv
// Directed bench for twiddle_frame_sequencer with a 2-cycle twiddle-stage model.
module tb_twiddle_frame_sequencer;

  localparam int NB_DATA  = 10;
  localparam int N        = 8;
  localparam int TMO      = 64;
  localparam int NB_FRAME = 8;
  localparam int LW       = 2 * NB_DATA;

  logic          i_clk = 1'b0;
  logic          i_rst, i_start, i_abort, i_clr_err, i_in_valid;
  logic          o_in_ready, o_tw_valid, o_busy, o_done, o_proto_err, o_timeout_err;
  logic [LW-1:0] i_in_signal_0, i_in_signal_1, i_in_signal_2, i_in_signal_3;
  logic [LW-1:0] o_tw_signal_0, o_tw_signal_1, o_tw_signal_2, o_tw_signal_3;
  logic          i_tw_valid = 1'b0;
  logic          i_tw_last  = 1'b0;
  logic [NB_FRAME-1:0] o_frame_cnt;

  int checks = 0;
  int errors = 0;

  // twiddle-stage model state (written only by the model process)
  int   last_at = N;
  int   ret_n   = 0;
  logic p0 = 1'b0, p1 = 1'b0;
  int   tv_seen = 0, done_seen = 0;

  always #5 i_clk = ~i_clk;

  twiddle_frame_sequencer #(
    .NB_DATA(NB_DATA), .N_SAMPLES(N), .TIMEOUT(TMO), .NB_FRAME(NB_FRAME)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_clr_err(i_clr_err), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_signal_0(i_in_signal_0), .i_in_signal_1(i_in_signal_1),
    .i_in_signal_2(i_in_signal_2), .i_in_signal_3(i_in_signal_3),
    .o_tw_valid(o_tw_valid),
    .o_tw_signal_0(o_tw_signal_0), .o_tw_signal_1(o_tw_signal_1),
    .o_tw_signal_2(o_tw_signal_2), .o_tw_signal_3(o_tw_signal_3),
    .i_tw_valid(i_tw_valid), .i_tw_last(i_tw_last), .o_busy(o_busy),
    .o_done(o_done), .o_frame_cnt(o_frame_cnt), .o_proto_err(o_proto_err),
    .o_timeout_err(o_timeout_err)
  );

  // Returns each forwarded beat two cycles later; raises last on return number last_at.
  always @(negedge i_clk) begin
    if (i_start) begin
      ret_n = 0;
      p0    = 1'b0;
      p1    = 1'b0;
    end
    i_tw_valid = p1;
    i_tw_last  = 1'b0;
    if (p1) begin
      ret_n++;
      i_tw_last = (ret_n == last_at);
    end
    p1 = p0;
    p0 = o_tw_valid;
    if (o_tw_valid) tv_seen++;
    if (o_done) done_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("busy_after_start", 32'(o_busy), 32'd1);
    check("ready_after_start", 32'(o_in_ready), 32'd1);
  endtask

  task automatic feed(input int nbeats, input int bubble_mask);
    int   k   = 0;
    int   cyc = 0;
    logic hs;
    while (k < nbeats && cyc < 4 * N) begin
      i_in_valid    = !bubble_mask[cyc];
      i_in_signal_0 = LW'(k);
      i_in_signal_1 = LW'(k * 3 + 1);
      i_in_signal_2 = LW'(k << 10);
      i_in_signal_3 = 20'hFFFFF - LW'(k);
      hs = i_in_valid && o_in_ready;
      tick();
      check("tw_valid", 32'(o_tw_valid), 32'(hs));
      if (hs) begin
        check("lane0", 32'(o_tw_signal_0), k);
        check("lane1", 32'(o_tw_signal_1), k * 3 + 1);
        check("lane2", 32'(o_tw_signal_2), k << 10);
        check("lane3", 32'(o_tw_signal_3), 32'h000FFFFF - k);
        k++;
      end else if (k > 0) begin
        check("lane0_hold", 32'(o_tw_signal_0), k - 1);
      end
      cyc++;
    end
    i_in_valid = 1'b0;
    check("beats_accepted", k, nbeats);
  endtask

  task automatic wait_done();
    int n = 0;
    while (o_done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("done_pulse", 32'(o_done), 32'd1);
  endtask

  task automatic run_frame();
    start_frame();
    feed(N, 0);
    wait_done();
  endtask

  initial begin
    int d0, t0, n;
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_clr_err = 1'b0; i_in_valid = 1'b0;
    i_in_signal_0 = '0; i_in_signal_1 = '0; i_in_signal_2 = '0; i_in_signal_3 = '0;
    repeat (2) tick();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ready", 32'(o_in_ready), 32'd0);
    check("rst_tw_valid", 32'(o_tw_valid), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    check("rst_proto", 32'(o_proto_err), 32'd0);
    check("rst_timeout", 32'(o_timeout_err), 32'd0);
    check("rst_lane0", 32'(o_tw_signal_0), 32'd0);
    i_rst = 1'b0;
    tick();

    // nominal frame
    last_at = N; d0 = done_seen; t0 = tv_seen;
    start_frame();
    feed(N, 0);
    check("nom_ready_drain", 32'(o_in_ready), 32'd0);
    check("nom_busy_drain", 32'(o_busy), 32'd1);
    wait_done();
    check("nom_frame_cnt", 32'(o_frame_cnt), 32'd1);
    check("nom_busy_idle", 32'(o_busy), 32'd0);
    check("nom_proto", 32'(o_proto_err), 32'd0);
    check("nom_timeout", 32'(o_timeout_err), 32'd0);
    tick();
    check("nom_done_one_cycle", 32'(o_done), 32'd0);
    check("nom_done_count", done_seen - d0, 32'd1);
    check("nom_valid_count", tv_seen - t0, N);

    // bubbles on cycles 3 and 5
    d0 = done_seen; t0 = tv_seen;
    start_frame();
    feed(N, (1 << 3) | (1 << 5));
    check("bub_ready_drop", 32'(o_in_ready), 32'd0);
    wait_done();
    check("bub_frame_cnt", 32'(o_frame_cnt), 32'd2);
    tick();
    check("bub_valid_count", tv_seen - t0, N);
    check("bub_done_count", done_seen - d0, 32'd1);

    // timeout: never assert last
    last_at = 0; d0 = done_seen;
    start_frame();
    feed(N, 0);
    n = 0;
    while (o_timeout_err !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, TMO);
    check("tmo_flag", 32'(o_timeout_err), 32'd1);
    check("tmo_busy", 32'(o_busy), 32'd0);
    check("tmo_frame_cnt", 32'(o_frame_cnt), 32'd2);
    check("tmo_no_done", done_seen - d0, 32'd0);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    check("tmo_cleared", 32'(o_timeout_err), 32'd0);

    // early last on the 6th return
    last_at = 6; d0 = done_seen;
    start_frame();
    feed(N, 0);
    n = 0;
    while (o_proto_err !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("early_proto", 32'(o_proto_err), 32'd1);
    check("early_busy", 32'(o_busy), 32'd0);
    repeat (5) tick();
    check("early_sticky", 32'(o_proto_err), 32'd1);
    check("early_no_done", done_seen - d0, 32'd0);
    check("early_frame_cnt", 32'(o_frame_cnt), 32'd2);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    check("early_cleared", 32'(o_proto_err), 32'd0);
    last_at = N;
    run_frame();
    check("after_early_frame_cnt", 32'(o_frame_cnt), 32'd3);
    check("after_early_proto", 32'(o_proto_err), 32'd0);
    tick();

    // abort mid-FEED after 4 beats
    d0 = done_seen;
    start_frame();
    feed(4, 0);
    check("abort_pre_ready", 32'(o_in_ready), 32'd1);
    i_abort = 1'b1; i_in_valid = 1'b1;
    tick();
    i_abort = 1'b0; i_in_valid = 1'b0;
    check("abort_ready", 32'(o_in_ready), 32'd0);
    check("abort_tw_valid", 32'(o_tw_valid), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    i_start = 1'b1; i_abort = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    check("start_abort_busy", 32'(o_busy), 32'd0);
    check("start_abort_ready", 32'(o_in_ready), 32'd0);
    repeat (4) tick();
    check("abort_no_done", done_seen - d0, 32'd0);
    check("abort_proto", 32'(o_proto_err), 32'd0);
    check("abort_frame_cnt", 32'(o_frame_cnt), 32'd3);

    // asynchronous reset during DRAIN
    last_at = 0;
    start_frame();
    feed(N, 0);
    repeat (3) tick();
    check("drain_busy", 32'(o_busy), 32'd1);
    #1 i_rst = 1'b1;
    #1;
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_ready", 32'(o_in_ready), 32'd0);
    check("arst_tw_valid", 32'(o_tw_valid), 32'd0);
    check("arst_lane0", 32'(o_tw_signal_0), 32'd0);
    check("arst_lane3", 32'(o_tw_signal_3), 32'd0);
    check("arst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    check("arst_done", 32'(o_done), 32'd0);
    tick();
    i_rst = 1'b0;
    repeat (4) tick();

    // 256 back-to-back frames: counter wraps 255 -> 0
    last_at = N;
    for (int f = 0; f < 255; f++) run_frame();
    check("wrap_255", 32'(o_frame_cnt), 32'd255);
    run_frame();
    check("wrap_0", 32'(o_frame_cnt), 32'd0);
    check("wrap_proto", 32'(o_proto_err), 32'd0);
    check("wrap_timeout", 32'(o_timeout_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
